// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared FSM state encoding and serial frame-bit levels for the
//               parity framed serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Frame sequencer states, one per frame field plus idle
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Line levels of the fixed frame bits
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_generator.sv
`default_nettype none
// ============================================================================
// Module      : parity_generator
// Description : Even parity over a data word: output is the XOR of all bits,
//               so data plus parity always carries an even number of ones.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_generator #(
    parameter int Width = 16
) (
    input  logic [Width-1:0] i_data,
    output logic             o_parity
);

    // Reduction XOR of the whole word
    assign o_parity = ^i_data;

endmodule : parity_generator
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_tx
// Description : Serial transmitter. Accepts a word over a valid/ready
//               handshake and sends start(0), data LSB first, even parity
//               and stop(1), each bit held for ClksPerBit clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int Width      = 16,
    parameter int ClksPerBit = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int BW = $clog2(Width);

    localparam logic [CW-1:0] c_cnt_last    = CW'(ClksPerBit - 1);
    // Counter value one cycle before the end of a bit; only consulted when
    // ClksPerBit > 1, so the clamp for ClksPerBit == 1 is never observed.
    localparam logic [CW-1:0] c_cnt_penult  = CW'((ClksPerBit > 1) ? (ClksPerBit - 2) : 0);
    localparam logic [BW-1:0] c_bit_last    = BW'(Width - 1);
    localparam logic          c_single_clk  = (ClksPerBit == 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [Width-1:0] r_data;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic             w_parity;
    logic             w_cnt_last;
    logic [BW-1:0]    w_bit_next;

    assign w_cnt_last = (r_cnt == c_cnt_last);
    assign w_bit_next = r_bit + BW'(1);

    // Parity of the captured word, stable for the whole frame
    parity_generator #(
        .Width (Width)
    ) u_parity_generator (
        .i_data   (r_data),
        .o_parity (w_parity)
    );

    // Frame sequencer: every output is registered and set one edge ahead of
    // the cycle it describes, so tx follows the state with no extra latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (in_valid && r_ready) begin
                        r_data  <= in_data;
                        r_state <= ST_START;
                        r_tx    <= START_BIT;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_tx    <= IDLE_LEVEL;
                        r_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_data[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_bit == c_bit_last) begin
                            r_bit   <= '0;
                            r_state <= ST_PARITY;
                            r_tx    <= w_parity;
                        end else begin
                            r_bit <= w_bit_next;
                            r_tx  <= r_data[w_bit_next];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                        r_tx    <= STOP_BIT;
                        // With one cycle per bit the first stop cycle is also the last
                        r_done  <= c_single_clk;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_tx    <= IDLE_LEVEL;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_done <= (r_cnt == c_cnt_penult);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign in_ready = r_ready;

endmodule : parity_frame_tx
`default_nettype wire

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter: Width, default 16, data word width in bits (>=2).
REQ-002 Parameter: ClksPerBit, default 4, clock cycles per serial bit (>=1).
REQ-003 Port: clk  input  1  sole clock; all logic is rising-edge triggered.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: in_data  input  Width  word to transmit.
REQ-006 Port: in_valid  input  1  in_data is valid.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: tx  output  1  serial line output; idle level 1.
REQ-009 Port: busy  output  1  a frame is in progress.
REQ-010 Port: done  output  1  one-cycle pulse during the final cycle of the stop bit.

Function
REQ-011 Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-012 in_ready shall be 1 only in IDLE.
REQ-013 in_data shall be registered on acceptance; later in_data and in_valid changes shall not affect the frame in flight.
REQ-014 Parity: parity bit = XOR of all Width bits of the captured word (even parity over data plus parity), computed combinationally from the captured register.
REQ-015 Frame order: start bit (0), data bits LSB first (bit 0 .. bit Width-1), parity bit, stop bit (1); Width+3 bits total.
REQ-016 Each frame bit shall drive tx for exactly ClksPerBit consecutive cycles.
REQ-017 Latency: if the word is accepted at edge E, the start bit shall appear on tx in the cycle after E.
REQ-018 Cycle timing, numbered from the cycle after E as cycle 1: data bit k occupies cycles (k+1)*ClksPerBit+1 .. (k+2)*ClksPerBit.
REQ-019 Frame occupancy shall be (Width+3)*ClksPerBit cycles.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-021 FSM transition: IDLE->START on acceptance.
REQ-022 FSM transition: START->DATA after ClksPerBit cycles.
REQ-023 FSM transition: DATA->PARITY after Width bits.
REQ-024 FSM transition: PARITY->STOP after ClksPerBit cycles.
REQ-025 FSM transition: STOP->IDLE after ClksPerBit cycles.
REQ-026 Counters: a cycle counter of width max(1,$clog2(ClksPerBit)) wraps at ClksPerBit-1; a bit index of width $clog2(Width) runs 0..Width-1 in DATA; neither counter shall overflow.
REQ-027 busy shall be 1 in every non-IDLE state and 0 in IDLE.
REQ-028 tx shall be 1 in IDLE.
REQ-029 tx, busy and in_ready shall be driven from registered state, with no combinational path from in_valid.
REQ-030 done shall be 1 only in the last cycle of STOP; in the following cycle the state is IDLE and in_ready=1.
REQ-031 Back-to-back: with in_valid held at 1, the next word shall be accepted at the first IDLE edge, leaving exactly one idle-high cycle between frames.
REQ-032 ClksPerBit=1 shall be supported with identical ordering and one cycle per bit.

Reset
REQ-033 While rst=1, the next state shall be IDLE with tx=1, busy=0, done=0, in_ready=0, and all counters and the data register cleared.
REQ-034 in_ready shall rise in the first cycle after rst is released.
REQ-035 rst asserted mid-frame shall abandon the frame: tx=1 from the next cycle, no done pulse, and the word shall not be resumed.
REQ-036 rst shall take priority over a simultaneous handshake; that word is not accepted.

Structure
REQ-037 FSM state encodings and frame-bit constants (START_BIT=0, STOP_BIT=1) shall reside in shared package parity_pkg.
REQ-038 Parity shall be computed by one instance of the existing parity_generator (Width passed through), fed from the captured data register.

Verification
REQ-039 Scenario (Width=16, ClksPerBit=4): send 16'h0001 -> tx 0 x4, 1 x4, then 0 for 15 bits x4, parity 1 x4, stop 1 x4; done at cycle 76.
REQ-040 Scenario: send 16'hFFFF -> parity bit 0; send 16'h8000 -> parity bit 1, MSB is the last data bit.
REQ-041 Scenario: in_valid held at 1 with 16'hA5A5 then 16'h0F0F -> two frames, second start bit 77 cycles after the first, one idle-high cycle between them.
REQ-042 Scenario: change in_data and pulse in_valid while busy -> in_ready=0, transmitted bits unchanged.
REQ-043 Scenario: assert rst at cycle 30 of a frame -> tx=1, busy=0 next cycle, no done; in_ready=1 the cycle after release.
REQ-044 Scenario: ClksPerBit=1, send 16'h0003 -> 19-cycle frame with parity 0.
